// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port with a one-entry write stage.
// The staged, uncommitted write is forwarded onto both read ports.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } stage_t;

  last_e  last_q;
  last_e  last_d;
  stage_t stage_q;
  stage_t stage_d;
  logic   grant_a;
  logic   grant_b;

  // State register: arbitration history and the write stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= LAST_B;
      stage_q <= '0;
    end else begin
      last_q  <= last_d;
      stage_q <= stage_d;
    end
  end

  // Grant selection and next stage contents; the stage empties when nothing transfers.
  always_comb begin
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    last_d       = last_q;
    stage_d      = stage_q;
    stage_d.we   = 1'b0;
    if (rst_n && !hold) begin
      if (a_valid && (!b_valid || (last_q == LAST_B))) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
    if (grant_a) begin
      last_d       = LAST_A;
      stage_d.we   = 1'b1;
      stage_d.addr = a_addr;
      stage_d.data = a_data;
    end else if (grant_b) begin
      last_d       = LAST_B;
      stage_d.we   = 1'b1;
      stage_d.addr = b_addr;
      stage_d.data = b_data;
    end
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;

  assign rf_we    = stage_q.we;
  assign rf_waddr = stage_q.addr;
  assign rf_wdata = stage_q.data;

  // Bypass the staged write so readers never see the stale register value.
  assign rd1 = (stage_q.we && (stage_q.addr == rs_addr)) ? stage_q.data : rf_rdata1;
  assign rd2 = (stage_q.we && (stage_q.addr == rt_addr)) ? stage_q.data : rf_rdata2;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file
// and a queue of expected commits checked on the write port.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        a_valid;
  logic [2:0]  a_addr;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [2:0]  b_addr;
  logic [15:0] b_data;
  logic        b_ready;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic [15:0] rf_rdata1;
  logic [15:0] rf_rdata2;
  logic [15:0] rd1;
  logic [15:0] rd2;

  logic [15:0] mem [8];

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   errors;

  regfile_write_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rd1       (rd1),
    .rd2       (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8x16 register file behind the write port.
  always @(posedge clk) begin
    if (rf_we) mem[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata1 = mem[rs_addr];
  assign rf_rdata2 = mem[rt_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_a(input logic v, input logic [2:0] ad, input logic [15:0] d);
    a_valid = v;
    a_addr  = ad;
    a_data  = d;
  endtask

  task automatic set_b(input logic v, input logic [2:0] ad, input logic [15:0] d);
    b_valid = v;
    b_addr  = ad;
    b_data  = d;
  endtask

  // Advance one cycle and check the write port against the scoreboard.
  task automatic cyc_start();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("commit_we", 32'(rf_we), 32'd1);
      chk("commit_addr", 32'(rf_waddr), 32'(e.addr));
      chk("commit_data", 32'(rf_wdata), 32'(e.data));
    end else begin
      chk("idle_we", 32'(rf_we), 32'd0);
    end
  endtask

  // Check the grant for the inputs just driven and record the expected commit.
  task automatic grant(input logic ea, input logic eb);
    exp_t e;
    #1;
    chk("a_ready", 32'(a_ready), 32'(ea));
    chk("b_ready", 32'(b_ready), 32'(eb));
    if (ea) begin
      e.addr = a_addr; e.data = a_data; e.due = cyc + 1;
      q.push_back(e);
    end
    if (eb) begin
      e.addr = b_addr; e.data = b_data; e.due = cyc + 1;
      q.push_back(e);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    rst_n = 1'b0; hold = 1'b0;
    rs_addr = 3'd0; rt_addr = 3'd0;
    set_a(1'b1, 3'd1, 16'h0101);
    set_b(1'b1, 3'd2, 16'h0202);

    // Reset state: no grants, empty stage.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    set_a(1'b0, 3'd0, 16'h0); set_b(1'b0, 3'd0, 16'h0);

    // Contention: alternate A, B, A, B starting with A.
    cyc_start(); rst_n = 1'b1;
    set_a(1'b1, 3'd1, 16'h0A01); set_b(1'b1, 3'd2, 16'h0B02);
    grant(1'b1, 1'b0);
    cyc_start(); grant(1'b0, 1'b1);
    cyc_start(); grant(1'b1, 1'b0);
    cyc_start(); grant(1'b0, 1'b1);
    cyc_start(); set_a(1'b0, 3'd0, 16'h0); set_b(1'b0, 3'd0, 16'h0); grant(1'b0, 1'b0);

    // Single write with one-cycle latency.
    cyc_start(); set_a(1'b1, 3'd3, 16'h1234); grant(1'b1, 1'b0);
    cyc_start(); set_a(1'b0, 3'd0, 16'h0); grant(1'b0, 1'b0);
    cyc_start(); grant(1'b0, 1'b0);

    // Forwarding on both read ports, then direct from the register file.
    cyc_start(); set_a(1'b1, 3'd5, 16'hBEEF); grant(1'b1, 1'b0);
    cyc_start(); set_a(1'b0, 3'd0, 16'h0);
    rs_addr = 3'd5; rt_addr = 3'd5; grant(1'b0, 1'b0);
    chk("fwd_rd1", 32'(rd1), 32'hBEEF);
    chk("fwd_rd2", 32'(rd2), 32'hBEEF);
    cyc_start(); rt_addr = 3'd3; grant(1'b0, 1'b0);
    chk("rf_rd1", 32'(rd1), 32'hBEEF);
    chk("rf_rd2", 32'(rd2), 32'h1234);

    // Stall: B staged before hold commits; A wins on release since last is B.
    cyc_start(); set_b(1'b1, 3'd6, 16'h0606); grant(1'b0, 1'b1);
    cyc_start(); hold = 1'b1;
    set_a(1'b1, 3'd1, 16'h1111); set_b(1'b1, 3'd2, 16'h2222); grant(1'b0, 1'b0);
    cyc_start(); grant(1'b0, 1'b0);
    cyc_start(); grant(1'b0, 1'b0);
    cyc_start(); hold = 1'b0; grant(1'b1, 1'b0);
    cyc_start(); set_a(1'b0, 3'd0, 16'h0); grant(1'b0, 1'b1);
    cyc_start(); set_b(1'b0, 3'd0, 16'h0); grant(1'b0, 1'b0);

    // Reset while a write of index 7 is staged: it must be discarded.
    cyc_start(); set_a(1'b1, 3'd7, 16'hAAAA); grant(1'b1, 1'b0);
    @(posedge clk); #1; cyc++;
    chk("pre_rst_we", 32'(rf_we), 32'd1);
    chk("pre_rst_addr", 32'(rf_waddr), 32'd7);
    rst_n = 1'b0; set_a(1'b0, 3'd0, 16'h0);
    #1;
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_waddr", 32'(rf_waddr), 32'd0);
    chk("mid_rst_wdata", 32'(rf_wdata), 32'd0);
    q.delete();
    cyc_start();
    cyc_start(); rst_n = 1'b1;
    set_a(1'b1, 3'd1, 16'h0C01); set_b(1'b1, 3'd2, 16'h0C02); grant(1'b1, 1'b0);
    cyc_start(); set_a(1'b0, 3'd0, 16'h0); grant(1'b0, 1'b1);
    cyc_start(); set_b(1'b0, 3'd0, 16'h0); grant(1'b0, 1'b0);

    // Back-to-back writes to index 4: B then A, later value wins.
    cyc_start(); set_b(1'b1, 3'd4, 16'h0001); grant(1'b0, 1'b1);
    cyc_start(); set_b(1'b0, 3'd0, 16'h0); set_a(1'b1, 3'd4, 16'h0002);
    rs_addr = 3'd4; grant(1'b1, 1'b0);
    chk("b2b_rd1_first", 32'(rd1), 32'h0001);
    cyc_start(); set_a(1'b0, 3'd0, 16'h0); grant(1'b0, 1'b0);
    chk("b2b_rd1_second", 32'(rd1), 32'h0002);
    cyc_start(); grant(1'b0, 1'b0);
    chk("b2b_rd1_settled", 32'(rd1), 32'h0002);
    cyc_start();

    chk("mem4_final", 32'(mem[4]), 32'h0002);
    chk("mem7_untouched", 32'(mem[7]), 32'h0000);
    chk("mem1_final", 32'(mem[1]), 32'h0C01);
    chk("mem6_final", 32'(mem[6]), 32'h0606);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 8 x 16-bit register file between two writeback requesters: A (ALU result) and B (memory load). It grants one requester per cycle using round-robin and registers the winning write into a one-entry stage that drives the register file write port on the next cycle. It also forwards that staged, not-yet-committed write onto the two read ports, so readers never see stale data. It sits between the execute/memory writeback paths and the register file.

## Interface
- DATA_W, 16, register data width (must match the register file)
- ADDR_W, 3, register index width (8 registers)

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous reset, active-low
- hold  in  1  pipeline stall; while 1, no new grants are issued
- a_valid  in  1  requester A has a write
- a_addr  in  ADDR_W  destination register index for A
- a_data  in  DATA_W  write data for A
- a_ready  out  1  A's write is accepted this cycle
- b_valid / b_addr / b_data / b_ready  same as A, for requester B
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write index
- rf_wdata  out  DATA_W  register file write data
- rs_addr, rt_addr  in  ADDR_W  read indices, also routed to the register file read ports
- rf_rdata1, rf_rdata2  in  DATA_W  raw register file read data for rs and rt
- rd1, rd2  out  DATA_W  forwarded read data for rs and rt

## Operation
- **Handshake:** a write transfers when valid and ready are both 1 in the same cycle.
  - ready is combinational from valid, hold and the arbiter state.
  - Requesters must not make valid depend on ready.
  - Once valid is asserted, the requester holds it, with addr and data stable, until the transfer.
- **Grants:** at most one of a_ready and b_ready is 1 in any cycle. Both are 0 while hold=1 or rst_n=0.
- **Round-robin:** a `last` register (A or B) resets to B, so A wins the first contest.
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not `last`.
  - `last` updates to the granted requester on every transfer and is unchanged otherwise.
- **Stage:** the stage register holds we, addr and data.
  - Each edge loads the transferring write, or loads we=0 when nothing transfers.
  - The stage always drains in one cycle. The write port never back-pressures the stage.
- **Outputs:** rf_we, rf_waddr and rf_wdata come directly from the stage register. There is no combinational path from the requesters to the write port.
- **Forwarding:**
  - rd1 = stage.data if stage.we=1 and stage.addr == rs_addr, otherwise rf_rdata1.
  - rd2 is computed the same way using rt_addr and rf_rdata2.
  - Both ports may forward in the same cycle.
- **Same-index writes:** consecutive writes to the same index are committed in grant order; the later write wins. No merging or dropping.
- **Reset:** rf_we=0, rf_waddr=0, rf_wdata=0, last=B.
  - An asserted rst_n=0 clears the stage immediately; a staged write is discarded and never committed.
  - rd1 and rd2 then equal the raw read data.

## Timing
- **Acceptance latency:** a write transferred in cycle N appears on rf_we, rf_waddr and rf_wdata in cycle N+1. The register file captures it at the rising edge that ends cycle N+1.
- **Forwarding window:** during cycle N+1, reads of that index return the new data through forwarding. From cycle N+2 the register file returns it directly.
- **Throughput:** one write per cycle, sustained. With both requesters continuously valid, grants alternate A, B, A, B.
- **hold:**
  - Takes effect in the same cycle it asserts.
  - A write already staged still commits in the following cycle.
  - Deasserting hold allows a grant in that same cycle. `last` is preserved across hold.
- **Reset release:** the first transfer can occur in the first cycle with rst_n=1.

## Test plan
- **Single write:** reset, then A writes addr=3, data=0x1234 with hold=0.
  - a_ready=1 in cycle N.
  - Cycle N+1: rf_we=1, rf_waddr=3, rf_wdata=0x1234.
  - Cycle N+2: rf_we=0.
- **Contention:** A and B both continuously valid for 4 cycles (A addr=1, B addr=2).
  - Grants are A, B, A, B; rf_waddr sequence is 1, 2, 1, 2; never both readies high.
- **Forwarding:** A writes addr=5, data=0xBEEF; the register file holds 0x0000 at index 5.
  - Cycle N+1: rs_addr=5 and rt_addr=5 give rd1 = rd2 = 0xBEEF.
  - Cycle N+2: rd1 = rf_rdata1 (now 0xBEEF from the register file).
- **Stall:** hold=1 for 3 cycles with A and B valid.
  - a_ready = b_ready = 0 throughout.
  - A write staged before the hold commits in the first hold cycle.
  - On hold release, the grant goes to the requester that is not `last`.
- **Reset mid-operation:** rst_n=0 asserted while the stage holds a write of addr=7, data=0xAAAA.
  - rf_we drops to 0 immediately; index 7 is never written.
  - After release, the first contest goes to A.
- **Back-to-back same index:** B writes addr=4 with 0x0001, then A writes addr=4 with 0x0002.
  - The register file ends at 0x0002.
  - rd1 for rs_addr=4 returns 0x0001, then 0x0002, in consecutive cycles.
